// File: rtl/sg90_pwm_multi.sv
// Multi-channel hobby-servo PWM generator.
// All channels share one prescaler/frame timebase. Requested widths are clamped
// into the safe servo range on write and only become active at a frame boundary,
// optionally rate-limited by a per-frame slew step.
module sg90_pwm_multi #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int CH          = 4,
    parameter int TICK_US     = 10,
    parameter int FRAME_TICKS = 2000,
    parameter int MIN_TICKS   = 50,
    parameter int MAX_TICKS   = 250,
    parameter int RESET_TICKS = 150,
    parameter int SLEW_TICKS  = 0,
    parameter int PW_W        = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [3:0]      wr_ch,
    input  logic [PW_W-1:0] wr_width,
    input  logic [CH-1:0]   ch_en,
    output logic [CH-1:0]   pwm,
    output logic [CH-1:0]   settled,
    output logic            frame_start
);

    localparam int PRESC = CLK_HZ / 1_000_000 * TICK_US;
    localparam int PS_W  = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESC - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
    localparam logic [PW_W-1:0] F_LAST  = PW_W'(FRAME_TICKS - 1);
    localparam logic [PW_W-1:0] F_ONE   = PW_W'(1);
    localparam logic [PW_W-1:0] MIN_W   = PW_W'(MIN_TICKS);
    localparam logic [PW_W-1:0] MAX_W   = PW_W'(MAX_TICKS);
    localparam logic [PW_W-1:0] RST_W   = PW_W'(RESET_TICKS);
    localparam logic [PW_W-1:0] SLEW_W  = PW_W'(SLEW_TICKS);

    logic [PS_W-1:0] presc_q;
    logic [PW_W-1:0] frame_q;
    logic [PW_W-1:0] frame_nxt;
    logic            tick;
    logic            boundary;
    logic [PW_W-1:0] wr_clamped;
    logic [CH-1:0]   en_q;
    logic [CH-1:0]   en_nxt;
    logic [PW_W-1:0] target_q   [CH];
    logic [PW_W-1:0] active_q   [CH];
    logic [PW_W-1:0] active_nxt [CH];

    // Move a width toward its target by at most SLEW_W; differences are taken
    // in the direction that cannot underflow.
    function automatic logic [PW_W-1:0] step_toward(input logic [PW_W-1:0] a,
                                                    input logic [PW_W-1:0] t);
        logic [PW_W-1:0] diff;
        if (SLEW_TICKS == 0) begin
            return t;
        end
        if (t > a) begin
            diff = t - a;
            return a + ((diff > SLEW_W) ? SLEW_W : diff);
        end
        diff = a - t;
        return a - ((diff > SLEW_W) ? SLEW_W : diff);
    endfunction

    // Timebase decode: tick ends each prescaler period, boundary ends each frame.
    always_comb begin
        tick      = (presc_q == PS_LAST);
        boundary  = tick && (frame_q == F_LAST);
        frame_nxt = frame_q;
        if (tick) begin
            frame_nxt = (frame_q == F_LAST) ? '0 : frame_q + F_ONE;
        end
    end

    // Clamp incoming widths into the servo-safe range.
    always_comb begin
        wr_clamped = wr_width;
        if (wr_width < MIN_W) begin
            wr_clamped = MIN_W;
        end else if (wr_width > MAX_W) begin
            wr_clamped = MAX_W;
        end
    end

    // Next active width and enable: only change at the frame boundary, using the
    // target as it stood before any write in the same cycle.
    always_comb begin
        en_nxt = boundary ? ch_en : en_q;
        for (int i = 0; i < CH; i++) begin
            active_nxt[i] = boundary ? step_toward(active_q[i], target_q[i]) : active_q[i];
        end
    end

    // A channel is settled once its active width has caught up with the target.
    always_comb begin
        settled = '0;
        for (int i = 0; i < CH; i++) begin
            settled[i] = (active_q[i] == target_q[i]);
        end
    end

    // Prescaler, frame counter and the registered frame_start flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            frame_q     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc_q     <= tick ? '0 : presc_q + PS_ONE;
            frame_q     <= frame_nxt;
            frame_start <= boundary;
        end
    end

    // Per-channel width registers and outputs. pwm is computed from next-state
    // values so the pulse rises together with the first cycle of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            pwm  <= '0;
            for (int i = 0; i < CH; i++) begin
                target_q[i] <= RST_W;
                active_q[i] <= RST_W;
            end
        end else begin
            en_q <= en_nxt;
            for (int i = 0; i < CH; i++) begin
                active_q[i] <= active_nxt[i];
                if (wr_en && (wr_ch == 4'(i))) begin
                    target_q[i] <= wr_clamped;
                end
                pwm[i] <= en_nxt[i] && (frame_nxt < active_nxt[i]);
            end
        end
    end

endmodule
